// File: rtl/ps2_key_decoder.sv
// PS/2 scan-code set 2 receiver and key-event decoder: turns raw ps2_clk/ps2_data into
// single-cycle press/release/enter pulses and color-decode levels for the game controller.
module ps2_key_decoder #(
   parameter int unsigned FILTER_LEN     = 4,
   parameter int unsigned TIMEOUT_CYCLES = 12500
) (
   input  logic clk,
   input  logic reset,
   input  logic ps2_clk,
   input  logic ps2_data,
   output logic key_pressed,
   output logic key_released,
   output logic enter_pressed,
   output logic valid_input,
   output logic input_eq_green,
   output logic input_eq_red,
   output logic input_eq_yellow,
   output logic input_eq_blue,
   output logic frame_error
);

   localparam int unsigned ToW = $clog2(TIMEOUT_CYCLES);
   localparam logic [ToW-1:0] ToMax = ToW'(TIMEOUT_CYCLES - 1);

   localparam logic [1:0] RxIdle   = 2'd0;
   localparam logic [1:0] RxData   = 2'd1;
   localparam logic [1:0] RxParity = 2'd2;
   localparam logic [1:0] RxStop   = 2'd3;

   localparam logic [1:0] DecIdle     = 2'd0;
   localparam logic [1:0] DecBreak    = 2'd1;
   localparam logic [1:0] DecExt      = 2'd2;
   localparam logic [1:0] DecExtBreak = 2'd3;

   // Levels packed as {valid, green, red, yellow, blue}.
   function automatic logic [4:0] color_lvl(input logic [7:0] code);
      case (code)
         8'h34:   color_lvl = 5'b11000;
         8'h2D:   color_lvl = 5'b10100;
         8'h35:   color_lvl = 5'b10010;
         8'h32:   color_lvl = 5'b10001;
         default: color_lvl = 5'b00000;
      endcase
   endfunction

   // ---------------- input conditioning ----------------
   logic [1:0]            clk_sync_q, data_sync_q;
   logic [FILTER_LEN-1:0] filt_sr_q;
   logic                  filt_q, filt_d;
   logic                  fall;
   logic                  data_s;

   // Idle PS/2 lines are high, so reset to 1s to avoid a spurious edge after reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         clk_sync_q  <= 2'b11;
         data_sync_q <= 2'b11;
         filt_sr_q   <= '1;
         filt_q      <= 1'b1;
      end else begin
         clk_sync_q  <= {clk_sync_q[0], ps2_clk};
         data_sync_q <= {data_sync_q[0], ps2_data};
         filt_sr_q   <= {filt_sr_q[FILTER_LEN-2:0], clk_sync_q[1]};
         filt_q      <= filt_d;
      end
   end

   always_comb begin
      filt_d = filt_q;
      if (filt_sr_q == '0) begin
         filt_d = 1'b0;
      end else if (&filt_sr_q) begin
         filt_d = 1'b1;
      end
      fall   = filt_q && (filt_sr_q == '0);
      data_s = data_sync_q[1];
   end

   // ---------------- receiver ----------------
   logic [1:0]     rx_state_q, rx_state_d;
   logic [2:0]     bit_cnt_q, bit_cnt_d;
   logic [7:0]     shift_q, shift_d;
   logic           parity_q, parity_d;
   logic [ToW-1:0] to_cnt_q, to_cnt_d;
   logic           byte_valid_q, byte_valid_d;
   logic           frame_err_q, frame_err_d;

   always_comb begin
      rx_state_d   = rx_state_q;
      bit_cnt_d    = bit_cnt_q;
      shift_d      = shift_q;
      parity_d     = parity_q;
      byte_valid_d = 1'b0;
      frame_err_d  = 1'b0;
      if (rx_state_q == RxIdle || fall) begin
         to_cnt_d = '0;
      end else begin
         to_cnt_d = to_cnt_q + ToW'(1);
      end

      case (rx_state_q)
         RxIdle: begin
            if (fall && !data_s) begin
               rx_state_d = RxData;
               bit_cnt_d  = 3'd0;
            end
         end
         RxData: begin
            if (fall) begin
               shift_d   = {data_s, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  rx_state_d = RxParity;
               end
            end
         end
         RxParity: begin
            if (fall) begin
               parity_d   = data_s;
               rx_state_d = RxStop;
            end
         end
         default: begin
            if (fall) begin
               if ((^{shift_q, parity_q}) && data_s) begin
                  byte_valid_d = 1'b1;
               end else begin
                  frame_err_d = 1'b1;
               end
               rx_state_d = RxIdle;
            end
         end
      endcase

      if (rx_state_q != RxIdle && !fall && to_cnt_q == ToMax) begin
         rx_state_d  = RxIdle;
         frame_err_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rx_state_q   <= RxIdle;
         bit_cnt_q    <= 3'd0;
         shift_q      <= 8'h00;
         parity_q     <= 1'b0;
         to_cnt_q     <= '0;
         byte_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         rx_state_q   <= rx_state_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         parity_q     <= parity_d;
         to_cnt_q     <= to_cnt_d;
         byte_valid_q <= byte_valid_d;
         frame_err_q  <= frame_err_d;
      end
   end

   // ---------------- decoder ----------------
   // shift_q still holds the received byte while byte_valid_q is high.
   logic [1:0] dec_state_q, dec_state_d;
   logic [7:0] held_code_q, held_code_d;
   logic       held_valid_q, held_valid_d;
   logic       enter_held_q, enter_held_d;
   logic       key_pressed_q, key_pressed_d;
   logic       key_released_q, key_released_d;
   logic       enter_pressed_q, enter_pressed_d;
   logic [4:0] lvl_q, lvl_d;

   always_comb begin
      dec_state_d     = dec_state_q;
      held_code_d     = held_code_q;
      held_valid_d    = held_valid_q;
      enter_held_d    = enter_held_q;
      key_pressed_d   = 1'b0;
      key_released_d  = 1'b0;
      enter_pressed_d = 1'b0;
      lvl_d           = lvl_q;

      if (byte_valid_q) begin
         case (dec_state_q)
            DecIdle: begin
               case (shift_q)
                  8'hE0: dec_state_d = DecExt;
                  8'hF0: dec_state_d = DecBreak;
                  8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: ;
                  8'h5A: begin
                     if (!enter_held_q) begin
                        enter_pressed_d = 1'b1;
                        enter_held_d    = 1'b1;
                     end
                  end
                  default: begin
                     if (!held_valid_q) begin
                        held_code_d   = shift_q;
                        held_valid_d  = 1'b1;
                        key_pressed_d = 1'b1;
                        lvl_d         = color_lvl(shift_q);
                     end
                  end
               endcase
            end
            DecBreak: begin
               if (shift_q == 8'h5A) begin
                  enter_held_d = 1'b0;
               end else if (held_valid_q && shift_q == held_code_q) begin
                  key_released_d = 1'b1;
                  held_valid_d   = 1'b0;
               end
               dec_state_d = DecIdle;
            end
            DecExt: begin
               dec_state_d = (shift_q == 8'hF0) ? DecExtBreak : DecIdle;
            end
            default: dec_state_d = DecIdle;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         dec_state_q     <= DecIdle;
         held_code_q     <= 8'h00;
         held_valid_q    <= 1'b0;
         enter_held_q    <= 1'b0;
         key_pressed_q   <= 1'b0;
         key_released_q  <= 1'b0;
         enter_pressed_q <= 1'b0;
         lvl_q           <= 5'b00000;
      end else begin
         dec_state_q     <= dec_state_d;
         held_code_q     <= held_code_d;
         held_valid_q    <= held_valid_d;
         enter_held_q    <= enter_held_d;
         key_pressed_q   <= key_pressed_d;
         key_released_q  <= key_released_d;
         enter_pressed_q <= enter_pressed_d;
         lvl_q           <= lvl_d;
      end
   end

   assign key_pressed     = key_pressed_q;
   assign key_released    = key_released_q;
   assign enter_pressed   = enter_pressed_q;
   assign valid_input     = lvl_q[4];
   assign input_eq_green  = lvl_q[3];
   assign input_eq_red    = lvl_q[2];
   assign input_eq_yellow = lvl_q[1];
   assign input_eq_blue   = lvl_q[0];
   assign frame_error     = frame_err_q;

endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Receives PS/2 scan-code set 2 frames from the keyboard and converts them into single-cycle key events and color-decode levels for the game controller FSM. It produces `key_pressed`, `key_released`, `enter_pressed`, `valid_input` and `input_eq_green/red/yellow/blue`. It sits between the board's PS/2 pins and the controller, and it handles filtering, deserialization, break/extended prefixes and typematic suppression.

## Interface
- `FILTER_LEN`, default 4: consecutive agreeing samples required before the filtered ps2_clk level changes.
- `TIMEOUT_CYCLES`, default 12500: clk cycles without a ps2_clk falling edge before a partial frame is aborted.
- `clk`  in  1  system clock; all logic runs on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `ps2_clk`  in  1  raw PS/2 clock (asynchronous).
- `ps2_data`  in  1  raw PS/2 data (asynchronous).
- `key_pressed`  out  1  one-cycle pulse on an accepted make code.
- `key_released`  out  1  one-cycle pulse on the break of the held key.
- `enter_pressed`  out  1  one-cycle pulse on an Enter (0x5A) make.
- `valid_input`  out  1  level: the last accepted make was a color key.
- `input_eq_green`, `input_eq_red`, `input_eq_yellow`, `input_eq_blue`  out  1 each  one-hot-or-zero levels for the last accepted make.
- `frame_error`  out  1  one-cycle pulse on a parity, stop-bit or timeout failure.

## Operation
- **Input conditioning**
  - ps2_clk and ps2_data each pass through a 2-FF synchronizer.
  - Synced ps2_clk feeds a FILTER_LEN shift register. The filtered level changes only when all FILTER_LEN samples agree.
  - A falling edge is a filtered 1→0 transition. Synced ps2_data is sampled in that same cycle.
- **Receiver FSM**, states R_IDLE, R_DATA, R_PARITY, R_STOP
  - R_IDLE: on an edge with data=0 (start bit), go to R_DATA with bit count 0. If data=1, stay in R_IDLE with no error.
  - R_DATA: shift in LSB first. After 8 bits, go to R_PARITY.
  - R_PARITY: capture the parity bit. Odd parity over the 8 data bits plus the parity bit is required.
  - R_STOP: capture the stop bit. If parity is good and stop=1, assert internal byte_valid for one cycle. Otherwise pulse frame_error and discard the byte. Return to R_IDLE in either case.
  - Timeout counter: cleared on every edge and while in R_IDLE. In any other state, reaching TIMEOUT_CYCLES-1 forces R_IDLE and pulses frame_error.
- **Decoder FSM**, states D_IDLE, D_BREAK, D_EXT, D_EXT_BREAK; advances only on byte_valid.
  - D_IDLE:
    - 0xE0 → D_EXT.
    - 0xF0 → D_BREAK.
    - 0x00, 0xAA, 0xEE, 0xFA, 0xFE, 0xFF are ignored.
    - 0x5A: if enter_held=0, pulse enter_pressed and set enter_held. Otherwise ignore it (typematic repeat).
    - Any other code: if held_valid=0, latch held_code, set held_valid, pulse key_pressed and update the color levels. If held_valid=1, ignore the code (repeat or second key).
  - D_BREAK:
    - 0x5A clears enter_held.
    - A code equal to held_code while held_valid=1 pulses key_released and clears held_valid.
    - Any other code has no effect.
    - Return to D_IDLE.
  - D_EXT: 0xF0 → D_EXT_BREAK. Any other byte is dropped and the FSM returns to D_IDLE. Extended keys never produce events.
  - D_EXT_BREAK: the byte is dropped and the FSM returns to D_IDLE.
- **Color map**, applied on an accepted make only: G=0x34, R=0x2D, Y=0x35, B=0x32.
  - For a color code, valid_input=1 and the matching input_eq_* is 1.
  - For any other code, valid_input=0 and all input_eq_* are 0.
  - The levels hold until the next accepted make.
- **Reset**
  - All outputs return to 0.
  - Receiver goes to R_IDLE, decoder to D_IDLE.
  - held_valid, enter_held and all counters clear.
  - A reset mid-frame discards the partial frame with no frame_error.

## Timing
- Let E be the cycle in which the filtered falling edge of the stop bit is detected. E is at most FILTER_LEN+3 cycles after the raw edge.
- byte_valid is asserted at E+1.
- key_pressed, key_released, enter_pressed, the color levels and held state all update at E+2.
- frame_error for a bad parity or stop bit is at E+1. A timeout frame_error occurs TIMEOUT_CYCLES cycles after the last edge.
- All pulses are exactly one cycle wide. At most one event pulse occurs per byte.
- A ps2_clk glitch shorter than FILTER_LEN cycles produces no edge.

## Test plan
All scenarios use FILTER_LEN=4, TIMEOUT_CYCLES=400 and a 40-cycle PS/2 bit period.

1. Send 0x34, then F0 34 → one key_pressed pulse, with input_eq_green=1 and valid_input=1 from E+2. Then one key_released pulse. Levels stay 1 after the release.
2. Send 2D, 2D, 2D, then F0 2D → exactly one key_pressed and one key_released; input_eq_red=1. Then send 5A, 5A, F0 5A → exactly one enter_pressed and no key_pressed.
3. Send 0x1C ('A') → key_pressed pulse, valid_input=0, all input_eq_*=0. Then 0x35 while 'A' is still held → no pulse. Then F0 1C followed by 0x35 → key_pressed with input_eq_yellow=1.
4. Send 0x35 with its parity bit flipped → frame_error pulse at E+1 and no key_pressed. Then send a good 0x32 → key_pressed with input_eq_blue=1.
5. Send 5 bits of a frame, then hold ps2_clk high for 500 cycles → one frame_error pulse and receiver in R_IDLE. Then send a full 0x34 → key_pressed with input_eq_green.
6. Add a 2-cycle low glitch on ps2_clk mid-frame → byte still decoded correctly. Send E0 34 and E0 F0 34 → no events. Assert reset mid-frame → all outputs 0, no frame_error, and the next 0x2D decodes normally.
